// File: rtl/mpt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpt_pkg
// Description : Shared types and constants for the MPT walker memory arbiter.
//               Holds the arbiter requester-ID type, the PLB port index, the
//               lock state encoding and an ID-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mpt_pkg;

  // Default walker configuration: PLB port plus three walking stages.
  localparam int MPTW_NUM_PORTS = 4;

  // The PLB lookup port always sits at requester index 0.
  localparam int MPTW_PLB_PORT = 0;

  // Requester-ID width. It is never narrower than one bit, so a single-port
  // build still has a legal vector type.
  function automatic int arb_id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  typedef logic [arb_id_width(MPTW_NUM_PORTS)-1:0] mptw_arb_id_t;

  // IDLE arbitrates each cycle. HELD pins the port that is waiting on m_mem_gnt.
  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage : mpt_pkg
`default_nettype wire

// File: rtl/mptw_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mptw_arb_id_fifo
// Description : Synchronous FIFO of requester IDs. It records which port owns
//               each in-flight memory transaction.
// Ports       : clk_i, rst_i     - clock, asynchronous active-high reset
//               push, push_id    - enqueue an ID (ignored when full)
//               pop              - dequeue the head (ignored when empty)
//               head             - oldest stored ID (registered storage)
//               count            - number of stored IDs
//               full, empty      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module mptw_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH need not be a power of two, so the pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : mptw_arb_id_fifo
`default_nettype wire

// File: rtl/mptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mptw_mem_arbiter
// Description : Round-robin arbiter that shares one memory slave port among
//               the PLB lookup port (index 0) and the walking-stage ports.
//               A port that is offered but not granted stays locked until
//               m_mem_gnt. The ID of each granted transaction is queued so
//               that in-order responses return to the port that issued them.
// Ports       : clk_i, rst_i          - clock, asynchronous active-high reset
//               s_mem_*               - per-requester request/response ports
//               m_mem_*               - downstream memory port
//               outstanding_o         - in-flight transaction count
//               protocol_error_o      - sticky: response with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module mptw_mem_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  s_mem_req,
  output logic [NUM_PORTS-1:0]                  s_mem_gnt,
  output logic [NUM_PORTS-1:0]                  s_mem_valid,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_mem_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  s_mem_wdata,
  input  logic [NUM_PORTS-1:0]                  s_mem_we,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] s_mem_be,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  s_mem_rdata,
  output logic [NUM_PORTS-1:0]                  s_mem_error,
  output logic                                  m_mem_req,
  input  logic                                  m_mem_gnt,
  input  logic                                  m_mem_valid,
  output logic [ADDR_WIDTH-1:0]                 m_mem_addr,
  output logic [DATA_WIDTH-1:0]                 m_mem_wdata,
  output logic                                  m_mem_we,
  output logic [DATA_WIDTH/8-1:0]               m_mem_be,
  input  logic [DATA_WIDTH-1:0]                 m_mem_rdata,
  input  logic                                  m_mem_error,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  protocol_error_o
);

  localparam int ID_W  = arb_id_width(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  lock_state_e     lock_state;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] rr_ptr;

  logic            sel_found;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] cur_id;
  logic            grant_done;
  logic            resp_pop;
  logic            resp_orphan;

  logic [ID_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Round-robin search. The first requester at or after rr_ptr wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      cand = ID_W'(idx);
      if (!sel_found && s_mem_req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // A locked port keeps the downstream request even if the FIFO has since
  // filled. The occupancy check only gates new offers made from IDLE.
  // A held transaction cannot have pushed, so the count cannot overflow.
  always_comb begin
    cur_id    = sel_id;
    m_mem_req = 1'b0;
    if (lock_state == LOCK_HELD) begin
      cur_id    = lock_id;
      m_mem_req = 1'b1;
    end else begin
      m_mem_req = sel_found & ~fifo_full;
    end
  end

  assign m_mem_addr  = s_mem_addr[cur_id];
  assign m_mem_wdata = s_mem_wdata[cur_id];
  assign m_mem_we    = s_mem_we[cur_id];
  assign m_mem_be    = s_mem_be[cur_id];

  assign grant_done  = m_mem_req & m_mem_gnt;
  assign resp_pop    = m_mem_valid & ~fifo_empty;
  assign resp_orphan = m_mem_valid & fifo_empty;

  always_comb begin
    s_mem_gnt   = '0;
    s_mem_valid = '0;
    s_mem_error = '0;
    if (grant_done) begin
      s_mem_gnt[cur_id] = 1'b1;
    end
    if (resp_pop) begin
      s_mem_valid[fifo_head] = 1'b1;
      s_mem_error[fifo_head] = m_mem_error;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
    assign s_mem_rdata[p] = m_mem_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_state       <= LOCK_IDLE;
      lock_id          <= '0;
      rr_ptr           <= ID_W'(MPTW_PLB_PORT);
      protocol_error_o <= 1'b0;
    end else begin
      case (lock_state)
        LOCK_IDLE: begin
          if (m_mem_req && !m_mem_gnt) begin
            lock_state <= LOCK_HELD;
            lock_id    <= sel_id;
          end
        end
        LOCK_HELD: begin
          if (m_mem_gnt) begin
            lock_state <= LOCK_IDLE;
          end
        end
        default: lock_state <= LOCK_IDLE;
      endcase
      if (grant_done) begin
        rr_ptr <= (cur_id == ID_W'(NUM_PORTS - 1)) ? '0 : cur_id + 1'b1;
      end
      if (resp_orphan) begin
        protocol_error_o <= 1'b1;
      end
    end
  end

  mptw_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (grant_done),
    .push_id (cur_id),
    .pop     (resp_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign outstanding_o = fifo_count;

endmodule : mptw_mem_arbiter
`default_nettype wire

// File: tb/tb_mptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mptw_mem_arbiter
// Description : Directed self-checking bench for mptw_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mptw_mem_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [3:0]       s_mem_req;
  logic [3:0]       s_mem_gnt;
  logic [3:0]       s_mem_valid;
  logic [3:0][63:0] s_mem_addr;
  logic [3:0][63:0] s_mem_wdata;
  logic [3:0]       s_mem_we;
  logic [3:0][7:0]  s_mem_be;
  logic [3:0][63:0] s_mem_rdata;
  logic [3:0]       s_mem_error;
  logic             m_mem_req;
  logic             m_mem_gnt;
  logic             m_mem_valid;
  logic [63:0]      m_mem_addr;
  logic [63:0]      m_mem_wdata;
  logic             m_mem_we;
  logic [7:0]       m_mem_be;
  logic [63:0]      m_mem_rdata;
  logic             m_mem_error;
  logic [2:0]       outstanding_o;
  logic             protocol_error_o;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  mptw_mem_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_valid(s_mem_valid),
    .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata), .s_mem_we(s_mem_we),
    .s_mem_be(s_mem_be), .s_mem_rdata(s_mem_rdata), .s_mem_error(s_mem_error),
    .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt), .m_mem_valid(m_mem_valid),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata), .m_mem_we(m_mem_we),
    .m_mem_be(m_mem_be), .m_mem_rdata(m_mem_rdata), .m_mem_error(m_mem_error),
    .outstanding_o(outstanding_o), .protocol_error_o(protocol_error_o)
  );

  // Each port gets a distinct payload so that the forwarded port can be identified.
  task automatic clear_inputs();
    s_mem_req   = '0;
    m_mem_gnt   = 1'b0;
    m_mem_valid = 1'b0;
    m_mem_rdata = '0;
    m_mem_error = 1'b0;
    for (int p = 0; p < 4; p++) begin
      s_mem_addr[p]  = 64'h100 * (p + 1);
      s_mem_wdata[p] = 64'hC0DE_0000 + 64'(p);
      s_mem_we[p]    = p[0];
      s_mem_be[p]    = 8'h0F << p;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (m_mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_m_req got=%b exp=0", m_mem_req); end
    vectors++; if (s_mem_gnt !== 4'b0) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", s_mem_gnt); end
    vectors++; if (s_mem_valid !== 4'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0000", s_mem_valid); end
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
    vectors++; if (protocol_error_o !== 1'b0) begin miscompares++; $display("FAIL reset_proterr got=%b exp=0", protocol_error_o); end
  endtask

  task automatic test_single_port();
    do_reset();
    @(negedge clk_i);
    s_mem_req = 4'b0100; s_mem_addr[2] = 64'h1000; m_mem_gnt = 1'b1;
    #1;
    vectors++; if (m_mem_req !== 1'b1) begin miscompares++; $display("FAIL single_m_req got=%b exp=1", m_mem_req); end
    vectors++; if (m_mem_addr !== 64'h1000) begin miscompares++; $display("FAIL single_addr got=%h exp=1000", m_mem_addr); end
    vectors++; if (s_mem_gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt got=%b exp=0100", s_mem_gnt); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL single_out1 got=%0d exp=1", outstanding_o); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      s_mem_req = '0; m_mem_gnt = 1'b0;
      #1;
      vectors++; if (s_mem_valid !== 4'b0) begin miscompares++; $display("FAIL single_idle_valid got=%b exp=0000", s_mem_valid); end
    end
    @(negedge clk_i);
    m_mem_valid = 1'b1; m_mem_rdata = 64'hDEAD;
    #1;
    vectors++; if (s_mem_valid !== 4'b0100) begin miscompares++; $display("FAIL single_valid got=%b exp=0100", s_mem_valid); end
    vectors++; if (s_mem_rdata[2] !== 64'hDEAD) begin miscompares++; $display("FAIL single_rdata got=%h exp=dead", s_mem_rdata[2]); end
    vectors++; if (s_mem_error !== 4'b0) begin miscompares++; $display("FAIL single_error got=%b exp=0000", s_mem_error); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL single_out0 got=%0d exp=0", outstanding_o); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  // Each cycle returns the response for the previous grant, so the count stays at 1.
  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] exp_v;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      s_mem_req = 4'b1111; m_mem_gnt = 1'b1; m_mem_valid = (c > 0);
      exp_g = 4'b0001 << (c % 4);
      exp_v = (c > 0) ? (4'b0001 << ((c - 1) % 4)) : 4'b0000;
      #1;
      vectors++; if (s_mem_gnt !== exp_g) begin miscompares++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, s_mem_gnt, exp_g); end
      vectors++; if (m_mem_addr !== 64'h100 * ((c % 4) + 1)) begin miscompares++; $display("FAIL rr_addr cycle=%0d got=%h exp=%h", c, m_mem_addr, 64'h100 * ((c % 4) + 1)); end
      vectors++; if (s_mem_valid !== exp_v) begin miscompares++; $display("FAIL rr_valid cycle=%0d got=%b exp=%b", c, s_mem_valid, exp_v); end
      @(posedge clk_i); #1;
      vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL rr_outstanding cycle=%0d got=%0d exp=1", c, outstanding_o); end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_lock_hold();
    logic [3:0] exp_g;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      s_mem_req = (c >= 2) ? 4'b1011 : 4'b1010;
      m_mem_gnt = (c == 5);
      exp_g = (c == 5) ? 4'b0010 : 4'b0000;
      #1;
      vectors++; if (m_mem_req !== 1'b1) begin miscompares++; $display("FAIL lock_m_req cycle=%0d got=%b exp=1", c, m_mem_req); end
      vectors++; if (m_mem_addr !== 64'h200 || m_mem_wdata !== 64'hC0DE_0001 || m_mem_we !== 1'b1 || m_mem_be !== 8'h1E) begin
        miscompares++; $display("FAIL lock_payload cycle=%0d got=%h/%h/%b/%h exp=200/c0de0001/1/1e", c, m_mem_addr, m_mem_wdata, m_mem_we, m_mem_be);
      end
      vectors++; if (s_mem_gnt !== exp_g) begin miscompares++; $display("FAIL lock_gnt cycle=%0d got=%b exp=%b", c, s_mem_gnt, exp_g); end
    end
    @(negedge clk_i);
    s_mem_req = 4'b1001; m_mem_gnt = 1'b1;
    #1;
    vectors++; if (s_mem_gnt !== 4'b1000) begin miscompares++; $display("FAIL lock_next_gnt got=%b exp=1000", s_mem_gnt); end
    vectors++; if (m_mem_addr !== 64'h400) begin miscompares++; $display("FAIL lock_next_addr got=%h exp=400", m_mem_addr); end
    @(negedge clk_i);
    s_mem_req = 4'b0001;
    #1;
    vectors++; if (s_mem_gnt !== 4'b0001) begin miscompares++; $display("FAIL lock_wrap_gnt got=%b exp=0001", s_mem_gnt); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      s_mem_req = 4'b1111; m_mem_gnt = 1'b1;
      #1;
      vectors++; if (s_mem_gnt !== (4'b0001 << c)) begin miscompares++; $display("FAIL max_gnt cycle=%0d got=%b exp=%b", c, s_mem_gnt, 4'b0001 << c); end
      @(posedge clk_i); #1;
      vectors++; if (outstanding_o !== 3'(c + 1)) begin miscompares++; $display("FAIL max_outstanding cycle=%0d got=%0d exp=%0d", c, outstanding_o, c + 1); end
    end
    @(negedge clk_i);
    #1;
    vectors++; if (m_mem_req !== 1'b0 || s_mem_gnt !== 4'b0) begin miscompares++; $display("FAIL max_full_block got=%b/%b exp=0/0000", m_mem_req, s_mem_gnt); end
    @(negedge clk_i);
    m_mem_valid = 1'b1;
    #1;
    vectors++; if (s_mem_valid !== 4'b0001) begin miscompares++; $display("FAIL max_resp_valid got=%b exp=0001", s_mem_valid); end
    vectors++; if (m_mem_req !== 1'b0) begin miscompares++; $display("FAIL max_resp_m_req got=%b exp=0", m_mem_req); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd3) begin miscompares++; $display("FAIL max_after_resp got=%0d exp=3", outstanding_o); end
    @(negedge clk_i);
    m_mem_valid = 1'b0;
    #1;
    vectors++; if (m_mem_req !== 1'b1 || s_mem_gnt !== 4'b0001) begin miscompares++; $display("FAIL max_resume got=%b/%b exp=1/0001", m_mem_req, s_mem_gnt); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd4) begin miscompares++; $display("FAIL max_refill got=%0d exp=4", outstanding_o); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge clk_i);
    s_mem_req = 4'b0010; m_mem_gnt = 1'b1;
    @(negedge clk_i);
    s_mem_req = 4'b0100;
    @(negedge clk_i);
    s_mem_req = 4'b1000; m_mem_valid = 1'b1; m_mem_error = 1'b1;
    #1;
    vectors++; if (outstanding_o !== 3'd2) begin miscompares++; $display("FAIL same_pre got=%0d exp=2", outstanding_o); end
    vectors++; if (s_mem_gnt !== 4'b1000) begin miscompares++; $display("FAIL same_gnt got=%b exp=1000", s_mem_gnt); end
    vectors++; if (s_mem_valid !== 4'b0010) begin miscompares++; $display("FAIL same_valid got=%b exp=0010", s_mem_valid); end
    vectors++; if (s_mem_error !== 4'b0010) begin miscompares++; $display("FAIL same_error got=%b exp=0010", s_mem_error); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd2) begin miscompares++; $display("FAIL same_post got=%0d exp=2", outstanding_o); end
    @(negedge clk_i);
    clear_inputs(); m_mem_valid = 1'b1;
    #1;
    vectors++; if (s_mem_valid !== 4'b0100) begin miscompares++; $display("FAIL same_next_valid got=%b exp=0100", s_mem_valid); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_protocol_error();
    do_reset();
    @(negedge clk_i);
    m_mem_valid = 1'b1;
    #1;
    vectors++; if (s_mem_valid !== 4'b0) begin miscompares++; $display("FAIL perr_valid got=%b exp=0000", s_mem_valid); end
    @(posedge clk_i); #1;
    vectors++; if (protocol_error_o !== 1'b1) begin miscompares++; $display("FAIL perr_set got=%b exp=1", protocol_error_o); end
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL perr_count got=%0d exp=0", outstanding_o); end
    @(negedge clk_i);
    m_mem_valid = 1'b0; s_mem_req = 4'b0001; m_mem_gnt = 1'b1;
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    vectors++; if (protocol_error_o !== 1'b1) begin miscompares++; $display("FAIL perr_sticky got=%b exp=1", protocol_error_o); end
    vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL perr_inflight got=%0d exp=1", outstanding_o); end
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    vectors++; if (protocol_error_o !== 1'b0) begin miscompares++; $display("FAIL perr_cleared got=%b exp=0", protocol_error_o); end
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL perr_out_cleared got=%0d exp=0", outstanding_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_port();
    test_round_robin();
    test_lock_hold();
    test_max_outstanding();
    test_same_cycle();
    test_protocol_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mptw_mem_arbiter
`default_nettype wire

// File: doc/mptw_mem_arbiter.md
# mptw_mem_arbiter

Shares one memory slave port among the MPT walker's memory masters: the PLB lookup port plus the `NUM_STAGES` walking-stage ports. It selects requesters round-robin and holds each request stable until it is granted. It records the requester ID of every granted transaction and routes in-order responses back to the requester that issued them. The block sits between `mptw_top` and the system memory interconnect.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requester ports; index 0 is the PLB port, indices 1..N are walking stages.
- `DATA_WIDTH`, 64: rdata/wdata width.
- `ADDR_WIDTH`, 64: address width.
- `MAX_OUTSTANDING`, 4: maximum number of granted transactions still awaiting a response; must be ≥1.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `s_mem_req` in [NUM_PORTS]: per-port request.
- `s_mem_gnt` out [NUM_PORTS]: per-port grant.
- `s_mem_valid` out [NUM_PORTS]: per-port response valid.
- `s_mem_addr` in [NUM_PORTS][ADDR_WIDTH]: per-port address.
- `s_mem_wdata` in [NUM_PORTS][DATA_WIDTH]: per-port write data.
- `s_mem_we` in [NUM_PORTS]: per-port write enable.
- `s_mem_be` in [NUM_PORTS][DATA_WIDTH/8]: per-port byte enables.
- `s_mem_rdata` out [NUM_PORTS][DATA_WIDTH]: read data; broadcast to all ports.
- `s_mem_error` out [NUM_PORTS]: response error; qualified per port by `s_mem_valid`.
- `m_mem_req` out 1, `m_mem_gnt` in 1, `m_mem_valid` in 1: downstream request/grant/response handshake.
- `m_mem_addr` out ADDR_WIDTH, `m_mem_wdata` out DATA_WIDTH, `m_mem_we` out 1, `m_mem_be` out DATA_WIDTH/8: downstream request payload.
- `m_mem_rdata` in DATA_WIDTH, `m_mem_error` in 1: downstream response.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current number of in-flight transactions.
- `protocol_error_o` out 1: sticky flag; set when a response arrives with nothing outstanding.

## Operation
- Protocol rule: a requester holds `req` and its payload stable until it sees `gnt`. Responses from downstream return in grant order, at least one cycle after `gnt`.
- State register `lock`, with sub-states IDLE and LOCKED(id):
  - IDLE: if any `s_mem_req` is set and `outstanding < MAX_OUTSTANDING`, select the first requesting port at or after pointer `rr_ptr` (wrap modulo NUM_PORTS). Drive `m_mem_req=1` and the selected port's payload.
    - If `m_mem_gnt` is set in the same cycle, complete the grant and stay IDLE.
    - Otherwise go to LOCKED(id).
  - LOCKED(id): keep forwarding port `id` regardless of other requests or of `rr_ptr`. On `m_mem_gnt`, complete the grant and return to IDLE.
- Grant completion:
  - `s_mem_gnt[id]=m_mem_gnt` (combinational).
  - Push `id` into the ID FIFO.
  - `rr_ptr <= (id+1) mod NUM_PORTS`.
- `m_mem_req` is never deasserted in LOCKED before `gnt`. The full-FIFO check applies only when entering from IDLE.
- Response routing: on `m_mem_valid`, pop the FIFO head `h`. Set `s_mem_valid[h]=1` and `s_mem_error[h]=m_mem_error`; all other `s_mem_valid` bits are 0.
- Push and pop in the same cycle: `outstanding` is unchanged. Push happens only when the count is below MAX_OUTSTANDING, so push-on-full cannot occur.
- `m_mem_valid` with the FIFO empty: drop the response, assert no `s_mem_valid`, set `protocol_error_o`. The flag clears only on reset.
- A requester that drops `req` before `gnt` violates the protocol; behaviour is undefined and need not be checked.

## Timing
- Request path is combinational: `s_mem_req` → `m_mem_req`, and `m_mem_gnt` → `s_mem_gnt`. The arbiter adds zero cycles of request latency.
- Response path is combinational: `m_mem_valid` → `s_mem_valid[h]`, using the registered FIFO head.
- `rr_ptr`, `lock`, the FIFO and `outstanding` update on the rising edge of `clk_i`.
- Reset values: `rr_ptr=0`, `lock=IDLE`, FIFO empty, `outstanding_o=0`, `protocol_error_o=0`. All `s_mem_gnt` and `s_mem_valid` bits are 0. `m_mem_req=0` unless a requester is active.
- Reset asserted mid-transaction discards all lock and FIFO state immediately. Downstream must be reset together with this block.

## Structure
- Add to `mpt_pkg`:
  - `mptw_arb_id_t`, width $clog2(NUM_PORTS), minimum 1.
  - `MPTW_PLB_PORT=0`.
- Sub-module `mptw_arb_id_fifo`: synchronous FIFO of depth MAX_OUTSTANDING. Provides push, pop, head, count, full and empty; pointers wrap modulo depth.
- Arbitration and lock logic live in the top module.

## Test plan
- Single port, addr 0x1000: only port 2 requests; `m_mem_gnt` in the same cycle; `m_mem_valid` 3 cycles later with rdata 0xDEAD → `s_mem_gnt[2]` in the same cycle, `s_mem_valid[2]` with 0xDEAD, `outstanding_o` goes 0→1→0.
- All 4 ports request continuously with `gnt` always 1 → grants follow 0,1,2,3,0,… with one grant per cycle.
- Ports 1 and 3 request; `gnt` withheld 5 cycles → port 1 payload held stable for all 5 cycles, then port 3 served next, even though port 0 requested mid-lock.
- MAX_OUTSTANDING=4 with no responses → exactly 4 grants, then `m_mem_req=0`. One `m_mem_valid` → `outstanding_o=3` and the next grant proceeds.
- Grant and response in the same cycle at `outstanding_o=2` → count stays 2; the response is routed to the oldest ID.
- `m_mem_valid` at reset state → no `s_mem_valid`, `protocol_error_o=1` and sticky. `rst_i` pulse → flag and `outstanding_o` return to 0.
